gate_seq_ctrl: RTL and testbench

GATE_SEQ_CTRL -- requirements
Module: gate_seq_ctrl

---
 rtl/gate_seq_pkg.sv | 23 ++
 rtl/gate_seq_dwell_cnt.sv | 29 ++
 rtl/gate_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_gate_seq_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/gate_seq_pkg.sv
// Shared FSM encodings, vector-count constants and truth-table helper for the gate sequencer.
package gate_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam int unsigned NUM_VEC  = 4;
  localparam int unsigned LAST_IDX = NUM_VEC - 1;
  localparam int unsigned IDX_W    = 2;

  // Expected {y1,y2,y3} for vector idx, taken column-wise from the three truth tables.
  function automatic logic [2:0] exp_bits(input logic [NUM_VEC-1:0] e1,
                                          input logic [NUM_VEC-1:0] e2,
                                          input logic [NUM_VEC-1:0] e3,
                                          input logic [IDX_W-1:0]   idx);
    return {e1[idx], e2[idx], e3[idx]};
  endfunction

endpackage

// File: rtl/gate_seq_dwell_cnt.sv
// Loadable down-counter that saturates at zero; is_zero_c flags an expired dwell.
module gate_seq_dwell_cnt
  import gate_seq_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         is_zero_c
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign is_zero_c = (count == '0);

endmodule

// File: rtl/gate_seq_ctrl.sv
// Truth-table sequencer: walks {a,b} through 00..11, checks y1/y2/y3 against exp1..3.
// Optional first-mismatch capture ports are built when GATE_SEQ_CAPTURE_EN is defined.
module gate_seq_ctrl
  import gate_seq_pkg::*;
#(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [3:0]         exp1,
  input  logic [3:0]         exp2,
  input  logic [3:0]         exp3,
  output logic               a,
  output logic               b,
  input  logic               y1,
  input  logic               y2,
  input  logic               y3,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [3:0]         err_vec,
`ifdef GATE_SEQ_CAPTURE_EN
  output logic [2:0]         fail_y,
  output logic [1:0]         fail_idx,
  output logic               fail_valid,
`endif
  output logic [1:0]         vec_idx
);

  state_t             state;
  logic               cnt_zero_c;
  logic               cnt_load_c;
  logic               cnt_dec_c;
  logic               last_vec_c;
  logic               mismatch_c;
  logic [2:0]         obs_c;
  logic [DWELL_W-1:0] dwell_m1_c;
  logic [IDX_W-1:0]   next_idx_c;

  // A dwell of zero behaves as one, so the reload value never wraps.
  assign dwell_m1_c = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
  assign last_vec_c = (vec_idx == IDX_W'(LAST_IDX));
  assign next_idx_c = vec_idx + IDX_W'(1);
  assign obs_c      = {y1, y2, y3};
  assign mismatch_c = (obs_c != exp_bits(exp1, exp2, exp3, vec_idx));
  assign cnt_load_c = ((state == ST_IDLE) && start) || ((state == ST_SAMPLE) && !last_vec_c);
  assign cnt_dec_c  = (state == ST_DRIVE);

  gate_seq_dwell_cnt #(.W(DWELL_W)) u_dwell_cnt (
    .clk       (clk),
    .reset     (reset),
    .load      (cnt_load_c),
    .dec       (cnt_dec_c),
    .load_val  (dwell_m1_c),
    .is_zero_c (cnt_zero_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      a       <= 1'b0;
      b       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_vec <= '0;
      vec_idx <= '0;
`ifdef GATE_SEQ_CAPTURE_EN
      fail_y     <= '0;
      fail_idx   <= '0;
      fail_valid <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            err_vec <= '0;
            pass    <= 1'b0;
            vec_idx <= '0;
            a       <= 1'b0;
            b       <= 1'b0;
            busy    <= 1'b1;
            state   <= ST_DRIVE;
`ifdef GATE_SEQ_CAPTURE_EN
            fail_y     <= '0;
            fail_idx   <= '0;
            fail_valid <= 1'b0;
`endif
          end
        end
        ST_DRIVE: begin
          if (cnt_zero_c) state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          if (mismatch_c) begin
            err_vec[vec_idx] <= 1'b1;
`ifdef GATE_SEQ_CAPTURE_EN
            if (!fail_valid) begin
              fail_y     <= obs_c;
              fail_idx   <= vec_idx;
              fail_valid <= 1'b1;
            end
`endif
          end
          if (last_vec_c) begin
            a     <= 1'b0;
            b     <= 1'b0;
            busy  <= 1'b0;
            state <= ST_FINISH;
          end else begin
            vec_idx <= next_idx_c;
            {a, b}  <= next_idx_c;
            state   <= ST_DRIVE;
          end
        end
        ST_FINISH: begin
          // err_vec already includes the last vector's compare here.
          done  <= 1'b1;
          pass  <= (err_vec == 4'b0000);
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// Self-checking bench for gate_seq_ctrl against a cycle-timeline reference model.
module tb_gate_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dwell = 8'd0;
  logic [3:0] exp1 = 4'd0, exp2 = 4'd0, exp3 = 4'd0;
  logic       a, b, y1, y2, y3, busy, done, pass;
  logic [3:0] err_vec;
  logic [1:0] vec_idx;
`ifdef GATE_SEQ_CAPTURE_EN
  logic [2:0] fail_y;
  logic [1:0] fail_idx;
  logic       fail_valid;
`endif

  int fault = 0;  // 0 none, 1 y2 stuck-0, 2 y1 stuck-1, 3 y3 inverted
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Gate datapath under test: AND / OR / XOR with an optional injected fault.
  function automatic logic [2:0] gate_model(input logic aa, input logic bb, input int f);
    logic [2:0] y;
    y = {aa & bb, aa | bb, aa ^ bb};
    if (f == 1) y[1] = 1'b0;
    if (f == 2) y[2] = 1'b1;
    if (f == 3) y[0] = ~y[0];
    return y;
  endfunction

  assign {y1, y2, y3} = gate_model(a, b, fault);

  gate_seq_ctrl #(.DWELL_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .dwell(dwell),
    .exp1(exp1), .exp2(exp2), .exp3(exp3),
    .a(a), .b(b), .y1(y1), .y2(y2), .y3(y3),
    .busy(busy), .done(done), .pass(pass), .err_vec(err_vec),
`ifdef GATE_SEQ_CAPTURE_EN
    .fail_y(fail_y), .fail_idx(fail_idx), .fail_valid(fail_valid),
`endif
    .vec_idx(vec_idx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_ab"}, 32'({a, b}), 32'd0);
  endtask

  // One sequence; restart_at pulses start during cycle t, abort_at asserts reset during cycle t.
  task automatic run_seq(input int dw, input logic [3:0] e1, input logic [3:0] e2,
                         input logic [3:0] e3, input int restart_at, input int abort_at);
    int d, n, first;
    logic [3:0] exp_err;
    logic [2:0] yv, ev, first_y;
    d = (dw == 0) ? 1 : dw;
    n = 4 * (d + 1);
    exp_err = '0;
    first = -1;
    first_y = '0;
    for (int i = 0; i < 4; i++) begin
      yv = gate_model(i[1], i[0], fault);
      ev = {e1[i], e2[i], e3[i]};
      if (yv != ev) begin
        exp_err[i] = 1'b1;
        if (first < 0) begin
          first = i;
          first_y = yv;
        end
      end
    end
    dwell = 8'(dw);
    exp1 = e1;
    exp2 = e2;
    exp3 = e3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 0; t < n; t++) begin
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_done", 32'(done), 32'd0);
      chk("run_ab", 32'({a, b}), 32'(t / (d + 1)));
      chk("run_idx", 32'(vec_idx), 32'(t / (d + 1)));
      if (t == abort_at) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_idle("abort");
        chk("abort_idx", 32'(vec_idx), 32'd0);
        chk("abort_err", 32'(err_vec), 32'd0);
        chk("abort_pass", 32'(pass), 32'd0);
`ifdef GATE_SEQ_CAPTURE_EN
        chk("abort_fvalid", 32'(fail_valid), 32'd0);
`endif
        for (int k = 0; k < n; k++) begin
          step();
          chk_idle("post_abort");
        end
        return;
      end
      start = (t == restart_at);
      step();
      start = 1'b0;
    end
    chk("fin_busy", 32'(busy), 32'd0);
    chk("fin_done", 32'(done), 32'd0);
    step();
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_ab", 32'({a, b}), 32'd0);
    chk("done_err", 32'(err_vec), 32'(exp_err));
    chk("done_pass", 32'(pass), 32'(exp_err == 4'b0000));
`ifdef GATE_SEQ_CAPTURE_EN
    chk("cap_valid", 32'(fail_valid), 32'(first >= 0));
    if (first >= 0) begin
      chk("cap_idx", 32'(fail_idx), 32'(first));
      chk("cap_y", 32'(fail_y), 32'(first_y));
    end
`endif
    for (int k = 0; k < 3; k++) begin
      step();
      chk_idle("after_done");
      chk("hold_err", 32'(err_vec), 32'(exp_err));
      chk("hold_pass", 32'(pass), 32'(exp_err == 4'b0000));
    end
  endtask

  initial begin
    logic [3:0] g1, g2, g3;
    // Golden truth tables derived from the fault-free gate model.
    g1 = '0; g2 = '0; g3 = '0;
    for (int i = 0; i < 4; i++) {g1[i], g2[i], g3[i]} = gate_model(i[1], i[0], 0);

    step();
    step();
    chk_idle("reset");
    chk("reset_pass", 32'(pass), 32'd0);
    chk("reset_err", 32'(err_vec), 32'd0);
    chk("reset_idx", 32'(vec_idx), 32'd0);
    reset = 1'b0;
    step();

    fault = 0;
    run_seq(2, 4'b1000, 4'b1110, 4'b0110, -1, -1);
    fault = 1;
    run_seq(2, 4'b1000, 4'b1110, 4'b0110, -1, -1);
    fault = 0;
    run_seq(0, g1, g2, g3, -1, -1);
    run_seq(2, g1, g2, g3, 3, -1);
    run_seq(2, g1, g2, g3, -1, 6);
    run_seq(2, g1, g2, g3, -1, -1);

    reset = 1'b1;
    start = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b0;
    chk_idle("rst_start");
    step();
    chk_idle("rst_start2");

    for (int r = 0; r < 12; r++) begin
      logic [3:0] r1, r2, r3;
      fault = int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        r1 = g1; r2 = g2; r3 = g3;
      end else begin
        r1 = 4'($urandom_range(0, 15));
        r2 = 4'($urandom_range(0, 15));
        r3 = 4'($urandom_range(0, 15));
      end
      run_seq(int'($urandom_range(0, 5)), r1, r2, r3, -1, -1);
    end

    fault = 0;
    run_seq(255, g1, g2, g3, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
